sin_phase_gen: RTL and testbench

Phase/angle sequencer that drives the 9-bit degree angle input of the sine lookup stage (get_sin_360_16) directly upstream of it. It is a degree-domain DDS accumulator: integer plus fractional step, modulo-360 wrap, and a programmable sample-rate divider. A start/stop state machine stops only on a wrap, so every waveform ends on a whole period. A delayed valid is aligned with the lookup's 1-cycle output latency.

---
 rtl/sin_phase_gen.sv | 174 +++++++++++++++++
 tb/tb_sin_phase_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sin_phase_gen.sv
// -----------------------------------------------------------------------------
// sin_phase_gen
//
// Degree-domain DDS phase sequencer feeding the 9-bit angle input of the
// get_sin_360_16 sine lookup. A fixed-point accumulator (9-bit integer degrees
// plus FRAC_BITS fractional bits) advances by step_int_i.step_frac_i once per
// sample tick and wraps modulo 360. A programmable divider sets the tick rate.
// A start/stop FSM only leaves the DRAIN state on a wrap, so every waveform
// ends on a whole period.
//
// Ports
//   clk_in          clock, all logic on the rising edge
//   rst_n_in        synchronous active-low reset
//   start_i         start request (IDLE only)
//   stop_i          stop request (RUN only), takes effect at the next wrap
//   phase_load_i    load phase_val_i into the accumulator (IDLE only)
//   phase_val_i     initial phase in degrees, values >= 360 clamp to 359
//   step_int_i      integer degrees per sample, values >= 360 clamp to 359
//   step_frac_i     fractional degrees per sample
//   div_i           one sample every div_i+1 clocks
//   angle_o         angle to the sine table, 0..359
//   angle_valid_o   1-cycle pulse, angle_o updated this cycle
//   sample_valid_o  angle_valid_o delayed one clock (qualifies the table output)
//   wrap_o          pulse with angle_valid_o when this advance crossed 360
//   busy_o          high in RUN and DRAIN
// -----------------------------------------------------------------------------
module sin_phase_gen #(
  parameter int FRAC_BITS = 16,
  parameter int DIV_BITS  = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 phase_load_i,
  input  logic [8:0]           phase_val_i,
  input  logic [8:0]           step_int_i,
  input  logic [FRAC_BITS-1:0] step_frac_i,
  input  logic [DIV_BITS-1:0]  div_i,
  output logic [8:0]           angle_o,
  output logic                 angle_valid_o,
  output logic                 sample_valid_o,
  output logic                 wrap_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [8:0]           acc_int_q, acc_int_d;
  logic [FRAC_BITS-1:0] acc_frac_q, acc_frac_d;
  logic [DIV_BITS-1:0]  div_cnt_q, div_cnt_d;
  logic [8:0]           angle_q, angle_d;
  logic                 angle_valid_q, angle_valid_d;
  logic                 sample_valid_q;
  logic                 wrap_q, wrap_d;
  logic                 busy_q, busy_d;

  // Saturated inputs: with both operands <= 359 the sum is <= 719, so a
  // single conditional subtraction of 360 always brings it back in range.
  logic [8:0]           step_int_sat;
  logic [8:0]           phase_clamped;
  logic [FRAC_BITS:0]   frac_sum;
  logic [9:0]           int_sum;
  logic [8:0]           int_next;
  logic                 wrap_now;
  logic                 step_zero;
  logic                 tick;
  logic                 drain_done;

  assign step_int_sat  = (step_int_i  >= 9'd360) ? 9'd359 : step_int_i;
  assign phase_clamped = (phase_val_i >= 9'd360) ? 9'd359 : phase_val_i;

  // Fraction carry propagates into the integer degrees.
  assign frac_sum  = {1'b0, acc_frac_q} + {1'b0, step_frac_i};
  assign int_sum   = {1'b0, acc_int_q} + {1'b0, step_int_sat}
                   + {9'd0, frac_sum[FRAC_BITS]};
  assign wrap_now  = (int_sum >= 10'd360);
  assign int_next  = wrap_now ? 9'(int_sum - 10'd360) : int_sum[8:0];

  assign step_zero = (step_int_sat == 9'd0) && (step_frac_i == '0);
  assign tick      = (state_q != S_IDLE) && (div_cnt_q == div_i);

  // A zero step can never wrap, so it is treated as wrapping for the
  // purpose of ending DRAIN; otherwise the generator would never stop.
  assign drain_done = (state_q == S_DRAIN) && tick && (wrap_now || step_zero);

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation and mismatch the synthesized flops.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q        <= S_IDLE;
      acc_int_q      <= '0;
      acc_frac_q     <= '0;
      div_cnt_q      <= '0;
      angle_q        <= '0;
      angle_valid_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_int_q      <= acc_int_d;
      acc_frac_q     <= acc_frac_d;
      div_cnt_q      <= div_cnt_d;
      angle_q        <= angle_d;
      angle_valid_q  <= angle_valid_d;
      sample_valid_q <= angle_valid_q;
      wrap_q         <= wrap_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i)    state_d = S_RUN;
      S_RUN:   if (stop_i)     state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    acc_int_d     = acc_int_q;
    acc_frac_d    = acc_frac_q;
    div_cnt_d     = div_cnt_q;
    angle_d       = angle_q;
    angle_valid_d = 1'b0;
    wrap_d        = 1'b0;
    busy_d        = (state_d != S_IDLE);

    if (state_q == S_IDLE) begin
      // Counter held at zero so the first tick lands div_i+1 clocks after
      // RUN entry.
      div_cnt_d = '0;
      if (phase_load_i) begin
        acc_int_d  = phase_clamped;
        acc_frac_d = '0;
      end
    end else if (tick) begin
      div_cnt_d     = '0;
      angle_d       = acc_int_q;  // pre-advance value
      angle_valid_d = 1'b1;
      wrap_d        = wrap_now;
      if (drain_done) begin
        acc_int_d  = '0;
        acc_frac_d = '0;
      end else begin
        acc_int_d  = int_next;
        acc_frac_d = frac_sum[FRAC_BITS-1:0];
      end
    end else begin
      div_cnt_d = div_cnt_q + {{(DIV_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign angle_o        = angle_q;
  assign angle_valid_o  = angle_valid_q;
  assign sample_valid_o = sample_valid_q;
  assign wrap_o         = wrap_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_sin_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_sin_phase_gen
//
// Directed scenarios with hand-derived expected values, followed by a long
// randomized run compared clock-by-clock against a behavioural model that
// keeps the phase as one integer count of 1/65536 degree, modulo 360 degrees.
// -----------------------------------------------------------------------------
module tb_sin_phase_gen;

  localparam int FB = 16;
  localparam int DB = 16;
  localparam longint ONE_DEG = 65536;
  localparam longint FULL    = 360 * 65536;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_i;
  logic          stop_i;
  logic          phase_load_i;
  logic [8:0]    phase_val_i;
  logic [8:0]    step_int_i;
  logic [FB-1:0] step_frac_i;
  logic [DB-1:0] div_i;
  logic [8:0]    angle_o;
  logic          angle_valid_o;
  logic          sample_valid_o;
  logic          wrap_o;
  logic          busy_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int     m_mode;   // 0 idle, 1 run, 2 drain
  longint m_phase;  // degrees * 65536, always < FULL
  int     m_cnt;
  int     m_angle;
  bit     m_av, m_sv, m_wrap, m_busy;

  sin_phase_gen #(.FRAC_BITS(FB), .DIV_BITS(DB)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .phase_load_i   (phase_load_i),
    .phase_val_i    (phase_val_i),
    .step_int_i     (step_int_i),
    .step_frac_i    (step_frac_i),
    .div_i          (div_i),
    .angle_o        (angle_o),
    .angle_valid_o  (angle_valid_o),
    .sample_valid_o (sample_valid_o),
    .wrap_o         (wrap_o),
    .busy_o         (busy_o)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_clock();
    longint step, np;
    longint sat;
    bit     w;
    if (!rst_n_in) begin
      m_mode = 0; m_phase = 0; m_cnt = 0; m_angle = 0;
      m_av = 0; m_sv = 0; m_wrap = 0; m_busy = 0;
      return;
    end
    m_sv = m_av; m_av = 0; m_wrap = 0;
    if (m_mode == 0) begin
      if (phase_load_i)
        m_phase = ((phase_val_i >= 9'd360) ? 359 : longint'(phase_val_i)) * ONE_DEG;
      if (start_i) begin m_mode = 1; m_cnt = 0; end
    end else if (m_cnt == int'(div_i)) begin
      sat  = (step_int_i >= 9'd360) ? 359 : longint'(step_int_i);
      step = sat * ONE_DEG + longint'(step_frac_i);
      np   = m_phase + step;
      w    = (np >= FULL);
      if (w) np = np - FULL;
      m_angle = int'(m_phase / ONE_DEG);
      m_av = 1; m_wrap = w; m_cnt = 0;
      if (m_mode == 2 && (w || step == 0)) begin m_mode = 0; np = 0; end
      else if (m_mode == 1 && stop_i) m_mode = 2;
      m_phase = np;
    end else begin
      m_cnt = (m_cnt + 1) % 65536;
      if (m_mode == 1 && stop_i) m_mode = 2;
    end
    m_busy = (m_mode != 0);
  endfunction

  // One clock: model advances on the same edge as the DUT, outputs settle #1 later.
  task automatic cyc();
    @(posedge clk_in);
    model_clock();
    #1;
  endtask

  task automatic quiet_inputs();
    start_i = 0; stop_i = 0; phase_load_i = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_n_in = 0; cyc(); cyc(); rst_n_in = 1;
  endtask

  // Start from a loaded phase; returns just after the RUN-entry edge.
  task automatic begin_run(input int ph, input int si, input int sf, input int dv);
    phase_load_i = 1; phase_val_i = 9'(ph);
    step_int_i = 9'(si); step_frac_i = FB'(sf); div_i = DB'(dv);
    start_i = 1;
    cyc();
    quiet_inputs();
  endtask

  task automatic test_reset();
    rst_n_in = 0; start_i = 1; phase_load_i = 1; phase_val_i = 9'd77;
    step_int_i = 9'd10; step_frac_i = '0; div_i = '0; stop_i = 0;
    cyc(); cyc();
    total++; if (angle_o !== 9'd0)      begin bad++; $display("FAIL reset_angle got=%0d want=0", angle_o); end
    total++; if (angle_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", angle_valid_o); end
    total++; if (sample_valid_o !== 1'b0) begin bad++; $display("FAIL reset_sample_valid got=%b want=0", sample_valid_o); end
    total++; if (wrap_o !== 1'b0)       begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap_o); end
    total++; if (busy_o !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    quiet_inputs(); rst_n_in = 1;
  endtask

  task automatic test_quarter();
    int exp_a[5] = '{0, 90, 180, 270, 0};
    do_reset();
    begin_run(0, 90, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      total++; if (angle_valid_o !== 1'b1) begin bad++; $display("FAIL quarter_valid[%0d] got=%b want=1", k, angle_valid_o); end
      total++; if (angle_o !== 9'(exp_a[k])) begin bad++; $display("FAIL quarter_angle[%0d] got=%0d want=%0d", k, angle_o, exp_a[k]); end
      total++; if (wrap_o !== (k == 3)) begin bad++; $display("FAIL quarter_wrap[%0d] got=%b want=%b", k, wrap_o, (k == 3)); end
      total++; if (sample_valid_o !== (k > 0)) begin bad++; $display("FAIL quarter_sample_valid[%0d] got=%b want=%b", k, sample_valid_o, (k > 0)); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL quarter_busy[%0d] got=%b want=1", k, busy_o); end
    end
  endtask

  task automatic test_divider();
    int exp_a[3] = '{350, 5, 20};
    int idx = 0;
    do_reset();
    begin_run(350, 15, 0, 2);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      total++; if (angle_valid_o !== (c % 3 == 0)) begin bad++; $display("FAIL div_valid clk%0d got=%b want=%b", c, angle_valid_o, (c % 3 == 0)); end
      if (c % 3 == 0) begin
        total++; if (angle_o !== 9'(exp_a[idx])) begin bad++; $display("FAIL div_angle[%0d] got=%0d want=%0d", idx, angle_o, exp_a[idx]); end
        total++; if (wrap_o !== (idx == 0)) begin bad++; $display("FAIL div_wrap[%0d] got=%b want=%b", idx, wrap_o, (idx == 0)); end
        idx++;
      end
    end
  endtask

  task automatic test_frac();
    int exp_a[4] = '{0, 0, 1, 1};
    int exp_b[3] = '{359, 359, 0};
    int exp_w[3] = '{0, 1, 0};
    do_reset();
    begin_run(0, 0, 'h8000, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      total++; if (angle_o !== 9'(exp_a[k]) || wrap_o !== 1'b0) begin bad++; $display("FAIL half_step[%0d] got=%0d/%b want=%0d/0", k, angle_o, wrap_o, exp_a[k]); end
    end
    // Near-one-degree fractional step: the wrap arrives through the carry.
    do_reset();
    begin_run(359, 0, 'hFFFF, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (angle_o !== 9'(exp_b[k]) || wrap_o !== 1'(exp_w[k])) begin bad++; $display("FAIL frac_wrap[%0d] got=%0d/%b want=%0d/%0d", k, angle_o, wrap_o, exp_b[k], exp_w[k]); end
    end
  endtask

  task automatic test_stop();
    do_reset();
    begin_run(0, 90, 0, 0);
    cyc(); cyc();            // ticks 0 and 90
    stop_i = 1;
    cyc();                   // tick 180, RUN -> DRAIN
    stop_i = 0;
    total++; if (angle_o !== 9'd180 || busy_o !== 1'b1) begin bad++; $display("FAIL stop_first got=%0d/%b want=180/1", angle_o, busy_o); end
    cyc();                   // tick 270 wraps, back to IDLE
    total++; if (angle_o !== 9'd270 || wrap_o !== 1'b1) begin bad++; $display("FAIL stop_last got=%0d/%b want=270/1", angle_o, wrap_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", busy_o); end
    cyc();
    total++; if (angle_valid_o !== 1'b0 || sample_valid_o !== 1'b1) begin bad++; $display("FAIL stop_tail got=%b/%b want=0/1", angle_valid_o, sample_valid_o); end
    start_i = 1; cyc(); start_i = 0;
    cyc();
    total++; if (angle_o !== 9'd0 || angle_valid_o !== 1'b1) begin bad++; $display("FAIL restart got=%0d/%b want=0/1", angle_o, angle_valid_o); end
  endtask

  task automatic test_stop_on_wrap();
    do_reset();
    begin_run(0, 180, 0, 0);
    cyc();                   // tick 0
    stop_i = 1;
    cyc();                   // tick 180 wraps on the stop edge: not counted
    stop_i = 0;
    total++; if (wrap_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL sow_first got=%b/%b want=1/1", wrap_o, busy_o); end
    cyc();
    total++; if (angle_o !== 9'd0 || busy_o !== 1'b1) begin bad++; $display("FAIL sow_mid got=%0d/%b want=0/1", angle_o, busy_o); end
    cyc();
    total++; if (angle_o !== 9'd180 || wrap_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL sow_end got=%0d/%b/%b want=180/1/0", angle_o, wrap_o, busy_o); end
  endtask

  task automatic test_saturate();
    int exp_a[3] = '{0, 359, 358};
    do_reset();
    begin_run(0, 400, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (angle_o !== 9'(exp_a[k]) || wrap_o !== (k > 0)) begin bad++; $display("FAIL sat[%0d] got=%0d/%b want=%0d/%b", k, angle_o, wrap_o, exp_a[k], (k > 0)); end
    end
  endtask

  task automatic test_zero_drain();
    do_reset();
    begin_run(100, 0, 0, 1);
    stop_i = 1;
    cyc();                   // no tick yet, RUN -> DRAIN
    stop_i = 0;
    cyc();                   // tick with zero step ends DRAIN
    total++; if (angle_valid_o !== 1'b1 || angle_o !== 9'd100) begin bad++; $display("FAIL zero_tick got=%b/%0d want=1/100", angle_valid_o, angle_o); end
    total++; if (wrap_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL zero_exit got=%b/%b want=0/0", wrap_o, busy_o); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    begin_run(0, 90, 0, 0);
    cyc(); cyc();
    rst_n_in = 0; start_i = 1;
    cyc();
    total++; if ({angle_o, angle_valid_o, sample_valid_o, wrap_o, busy_o} !== 13'd0) begin bad++; $display("FAIL midreset got=%0d/%b/%b/%b/%b want=all 0", angle_o, angle_valid_o, sample_valid_o, wrap_o, busy_o); end
    rst_n_in = 1; start_i = 0;
    cyc();
    total++; if (busy_o !== 1'b0 || angle_valid_o !== 1'b0) begin bad++; $display("FAIL midreset_idle got=%b/%b want=0/0", busy_o, angle_valid_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n_in     = ($urandom_range(0, 499) != 0);
      start_i      = ($urandom_range(0, 7) == 0);
      stop_i       = ($urandom_range(0, 15) == 0);
      phase_load_i = ($urandom_range(0, 3) == 0);
      phase_val_i  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 31) == 0) step_int_i = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 31) == 0) step_frac_i = FB'($urandom);
      if (m_mode == 0) div_i = DB'($urandom_range(0, 3));
      cyc();
      total++; if (angle_o !== 9'(m_angle)) begin bad++; $display("FAIL rnd_angle n=%0d got=%0d want=%0d", n, angle_o, m_angle); end
      total++; if (angle_valid_o !== m_av) begin bad++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, angle_valid_o, m_av); end
      total++; if (sample_valid_o !== m_sv) begin bad++; $display("FAIL rnd_sample_valid n=%0d got=%b want=%b", n, sample_valid_o, m_sv); end
      total++; if (wrap_o !== m_wrap) begin bad++; $display("FAIL rnd_wrap n=%0d got=%b want=%b", n, wrap_o, m_wrap); end
      total++; if (busy_o !== m_busy) begin bad++; $display("FAIL rnd_busy n=%0d got=%b want=%b", n, busy_o, m_busy); end
    end
    rst_n_in = 1;
  endtask

  initial begin
    rst_n_in = 0; quiet_inputs();
    phase_val_i = '0; step_int_i = '0; step_frac_i = '0; div_i = '0;
    test_reset();
    test_quarter();
    test_divider();
    test_frac();
    test_stop();
    test_stop_on_wrap();
    test_saturate();
    test_zero_drain();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
